// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch-control stage and its instruction memory.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_START,
    ST_RUN,
    ST_HALTED
  } fetch_state_t;

  localparam int unsigned DEF_PROG_CTR_WID = 10;
  localparam int unsigned FETCH_RESET_VEC  = 0;
  localparam int unsigned DEF_RAS_DEPTH    = 4;
  // Registered read latency of the instruction memory, in cycles.
  localparam int unsigned IMEM_RD_LATENCY  = 1;

endpackage

// File: rtl/fetch_ctrl_ret_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty yields EMPTY_VAL and leaves the stack empty.
module ret_addr_stack
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned    WID       = DEF_PROG_CTR_WID,
  parameter int unsigned    DEPTH     = DEF_RAS_DEPTH,
  parameter logic [WID-1:0] EMPTY_VAL = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           push,
  input  logic           pop,
  input  logic [WID-1:0] push_data,
  output logic [WID-1:0] pop_data,
  output logic           full,
  output logic           empty,
  output logic           ovf,
  output logic           unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WID-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;

  // wr_ptr is the next free slot; when full it also points at the oldest entry,
  // so an overflowing push overwrites exactly that one.
  assign top_ptr  = wr_ptr - PTR_W'(1);
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~pop;
  assign ovf      = do_push & full;
  assign unf      = pop & empty;
  assign pop_data = empty ? EMPTY_VAL : mem[top_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (pop) begin
      if (!empty) begin
        wr_ptr <= top_ptr;
        count  <= count - CNT_W'(1);
      end
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter / fetch control with squash-on-redirect and a return-address stack.
// Optional: define FETCH_RAS_ERR_EN to build the sticky RAS overflow/underflow flag.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned             PROG_CTR_WID = DEF_PROG_CTR_WID,
  parameter logic [PROG_CTR_WID-1:0] RESET_VEC    = PROG_CTR_WID'(FETCH_RESET_VEC),
  parameter int unsigned             RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic                    br_taken,
  input  logic                    call,
  input  logic                    ret,
  input  logic [PROG_CTR_WID-1:0] br_target,
  input  logic                    halt,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  output logic [PROG_CTR_WID-1:0] fetch_pc,
  output logic                    instr_valid,
  output logic                    halted,
  output logic                    ras_err
);

  localparam logic [PROG_CTR_WID-1:0] PC_ONE = PROG_CTR_WID'(1);

  fetch_state_t              state, state_nxt;
  logic [PROG_CTR_WID-1:0]   pc_nxt, fpc_nxt;
  logic                      valid_nxt;
  logic                      ras_push, ras_pop;
  logic [PROG_CTR_WID-1:0]   ras_push_data, ras_pop_data;
  logic                      ras_full, ras_empty, ras_ovf, ras_unf;

  assign ras_push_data = fetch_pc + PC_ONE;
  assign halted        = (state == ST_HALTED);

  ret_addr_stack #(
    .WID       (PROG_CTR_WID),
    .DEPTH     (RAS_DEPTH),
    .EMPTY_VAL (RESET_VEC)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ras_push_data),
    .pop_data  (ras_pop_data),
    .full      (ras_full),
    .empty     (ras_empty),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    fpc_nxt   = fetch_pc;
    valid_nxt = instr_valid;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    unique case (state)
      ST_START: begin
        state_nxt = ST_RUN;
        fpc_nxt   = prog_ctr;
        pc_nxt    = prog_ctr + PC_ONE;
        valid_nxt = 1'b1;
      end
      ST_RUN: begin
        // A redirect only clears valid; the following sequential cycle picks up
        // the target word from memory and re-asserts it.
        if (halt) begin
          state_nxt = ST_HALTED;
          valid_nxt = 1'b0;
        end else if (ret) begin
          ras_pop   = 1'b1;
          pc_nxt    = ras_pop_data;
          valid_nxt = 1'b0;
        end else if (call) begin
          ras_push  = 1'b1;
          pc_nxt    = br_target;
          valid_nxt = 1'b0;
        end else if (br_taken) begin
          pc_nxt    = br_target;
          valid_nxt = 1'b0;
        end else if (!stall) begin
          fpc_nxt   = prog_ctr;
          pc_nxt    = prog_ctr + PC_ONE;
          valid_nxt = 1'b1;
        end
      end
      ST_HALTED: ;
      default: state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_START;
      prog_ctr    <= RESET_VEC;
      fetch_pc    <= RESET_VEC;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      prog_ctr    <= pc_nxt;
      fetch_pc    <= fpc_nxt;
      instr_valid <= valid_nxt;
    end
  end

`ifdef FETCH_RAS_ERR_EN
  logic err_q;
  logic unused_ras;
  assign unused_ras = ras_full ^ ras_empty;

  always_ff @(posedge clk) begin
    if (!reset_n)               err_q <= 1'b0;
    else if (ras_ovf | ras_unf) err_q <= 1'b1;
  end
  assign ras_err = err_q;
`else
  logic unused_ras;
  assign unused_ras = ^{ras_full, ras_empty, ras_ovf, ras_unf};
  assign ras_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_fetch_ctrl;

  localparam int unsigned W     = 10;
  localparam int unsigned DEPTH = 4;
  localparam logic [W-1:0] RV   = 10'h000;
`ifdef FETCH_RAS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         stall = 1'b0, br_taken = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0;
  logic [W-1:0] br_target = '0;
  logic [W-1:0] prog_ctr, fetch_pc;
  logic         instr_valid, halted, ras_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] m_pc, m_fpc;
  logic         m_valid, m_halted, m_started, m_err;
  logic [W-1:0] m_ras[$];

  always #5 clk = ~clk;

  fetch_ctrl #(
    .PROG_CTR_WID (W),
    .RESET_VEC    (RV),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .br_taken    (br_taken),
    .call        (call),
    .ret         (ret),
    .br_target   (br_target),
    .halt        (halt),
    .prog_ctr    (prog_ctr),
    .fetch_pc    (fetch_pc),
    .instr_valid (instr_valid),
    .halted      (halted),
    .ras_err     (ras_err)
  );

  // One clock; model follows the inputs the DUT sampled at that edge.
  task automatic step();
    logic [W-1:0] tgt;
    @(posedge clk);
    if (!reset_n) begin
      m_pc = RV; m_fpc = RV; m_valid = 0; m_halted = 0; m_started = 0; m_err = 0;
      m_ras.delete();
    end else if (!m_started) begin
      m_started = 1; m_fpc = m_pc; m_pc = m_pc + 10'd1; m_valid = 1;
    end else if (m_halted) begin
    end else if (halt) begin
      m_halted = 1; m_valid = 0;
    end else if (ret) begin
      if (m_ras.size() == 0) begin
        tgt = RV;
        if (ERR_EN) m_err = 1;
      end else begin
        tgt = m_ras.pop_back();
      end
      m_pc = tgt; m_valid = 0;
    end else if (call) begin
      m_ras.push_back(m_fpc + 10'd1);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        if (ERR_EN) m_err = 1;
      end
      m_pc = br_target; m_valid = 0;
    end else if (br_taken) begin
      m_pc = br_target; m_valid = 0;
    end else if (!stall) begin
      m_fpc = m_pc; m_pc = m_pc + 10'd1; m_valid = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    step();
    step();
    checks++;
    if ({prog_ctr, fetch_pc, instr_valid, halted, ras_err} !== {RV, RV, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: pc=%h fpc=%h v=%b h=%b e=%b, want pc=%h fpc=%h v=0 h=0 e=0",
               prog_ctr, fetch_pc, instr_valid, halted, ras_err, RV, RV);
    end
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (fetch_pc !== W'(i) || prog_ctr !== W'(i + 1) || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL startup_seq[%0d]: pc=%h fpc=%h v=%b, want pc=%h fpc=%h v=1",
                 i, prog_ctr, fetch_pc, instr_valid, W'(i + 1), W'(i));
      end
    end
  endtask

  task automatic test_branch();
    for (int n = 0; n < 20 && fetch_pc !== 10'h005; n++) step();
    checks++;
    if (fetch_pc !== 10'h005) begin
      errors++;
      $display("FAIL branch_wait: fpc=%h, want 005 within 20 cycles", fetch_pc);
    end
    br_taken = 1; br_target = 10'h200;
    step();
    br_taken = 0;
    checks++;
    if (instr_valid !== 1'b0 || prog_ctr !== 10'h200) begin
      errors++;
      $display("FAIL branch_squash: v=%b pc=%h, want v=0 pc=200", instr_valid, prog_ctr);
    end
    step();
    checks++;
    if (fetch_pc !== 10'h200 || instr_valid !== 1'b1 || prog_ctr !== 10'h201) begin
      errors++;
      $display("FAIL branch_target: fpc=%h v=%b pc=%h, want fpc=200 v=1 pc=201",
               fetch_pc, instr_valid, prog_ctr);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp_fpc [3];
    logic [W-1:0] exp_pc  [3];
    exp_fpc = '{10'h3FE, 10'h3FF, 10'h000};
    exp_pc  = '{10'h3FF, 10'h000, 10'h001};
    br_taken = 1; br_target = 10'h3FE;
    step();
    br_taken = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fetch_pc !== exp_fpc[i] || prog_ctr !== exp_pc[i] || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap[%0d]: fpc=%h pc=%h v=%b, want fpc=%h pc=%h v=1",
                 i, fetch_pc, prog_ctr, instr_valid, exp_fpc[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_call_ret();
    br_taken = 1; br_target = 10'h010;
    step();
    br_taken = 0;
    step();
    call = 1; br_target = 10'h080;
    step();
    call = 0;
    step();
    checks++;
    if (fetch_pc !== 10'h080 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL call_target: fpc=%h v=%b, want fpc=080 v=1", fetch_pc, instr_valid);
    end
    for (int n = 0; n < 20 && fetch_pc !== 10'h085; n++) step();
    ret = 1;
    step();
    ret = 0;
    step();
    checks++;
    if (fetch_pc !== 10'h011 || instr_valid !== 1'b1 || ras_err !== 1'b0) begin
      errors++;
      $display("FAIL call_ret_resume: fpc=%h v=%b e=%b, want fpc=011 v=1 e=0",
               fetch_pc, instr_valid, ras_err);
    end
  endtask

  task automatic test_nested_calls();
    logic [W-1:0] ret_exp [5];
    logic [W-1:0] want;
    for (int k = 0; k < 5; k++) begin
      ret_exp[k] = fetch_pc + 10'd1;
      call = 1; br_target = W'(32'h100 + 32'h40 * k);
      step();
      call = 0;
      step();
    end
    for (int k = 0; k < 5; k++) begin
      want = (k < 4) ? ret_exp[4 - k] : RV;
      ret = 1;
      step();
      ret = 0;
      step();
      checks++;
      if (fetch_pc !== want || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL nested_ret[%0d]: fpc=%h v=%b, want fpc=%h v=1", k, fetch_pc, instr_valid, want);
      end
    end
    checks++;
    if (ras_err !== ERR_EN) begin
      errors++;
      $display("FAIL ras_err_flag: e=%b, want %b", ras_err, ERR_EN);
    end
  endtask

  task automatic test_stall_halt();
    logic [2*W:0] snap;
    logic [W-1:0] pc_snap;
    step();
    step();
    snap = {prog_ctr, fetch_pc, instr_valid};
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({prog_ctr, fetch_pc, instr_valid} !== snap) begin
        errors++;
        $display("FAIL stall_hold[%0d]: pc=%h fpc=%h v=%b, want pc=%h fpc=%h v=%b", i,
                 prog_ctr, fetch_pc, instr_valid, snap[2*W:W+1], snap[W:1], snap[0]);
      end
    end
    br_taken = 1; br_target = 10'h2A0;
    step();
    br_taken = 0; stall = 0;
    checks++;
    if (prog_ctr !== 10'h2A0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_redirect: pc=%h v=%b, want pc=2a0 v=0", prog_ctr, instr_valid);
    end
    step();
    checks++;
    if (fetch_pc !== 10'h2A0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_redirect_fetch: fpc=%h v=%b, want fpc=2a0 v=1", fetch_pc, instr_valid);
    end
    pc_snap = prog_ctr;
    halt = 1; br_taken = 1; br_target = 10'h155;
    for (int i = 0; i < 3; i++) begin
      step();
      halt = 0;
      checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || prog_ctr !== pc_snap) begin
        errors++;
        $display("FAIL halt_hold[%0d]: h=%b v=%b pc=%h, want h=1 v=0 pc=%h",
                 i, halted, instr_valid, prog_ctr, pc_snap);
      end
    end
    br_taken = 0;
    reset_n = 0;
    step();
    reset_n = 1;
    checks++;
    if ({prog_ctr, fetch_pc, instr_valid, halted, ras_err} !== {RV, RV, 3'b000}) begin
      errors++;
      $display("FAIL reset_after_halt: pc=%h fpc=%h v=%b h=%b e=%b, want pc=%h fpc=%h v=0 h=0 e=0",
               prog_ctr, fetch_pc, instr_valid, halted, ras_err, RV, RV);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset_n   = !(m_halted && ($urandom_range(0, 3) == 0));
      halt      = ($urandom_range(0, 59) == 0);
      ret       = ($urandom_range(0, 6) == 0);
      call      = ($urandom_range(0, 5) == 0);
      br_taken  = ($urandom_range(0, 8) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      br_target = W'($urandom);
      step();
      checks++;
      if ({prog_ctr, fetch_pc, instr_valid, halted, ras_err} !==
          {m_pc, m_fpc, m_valid, m_halted, m_err}) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h fpc=%h v=%b h=%b e=%b, want pc=%h fpc=%h v=%b h=%b e=%b",
                 i, prog_ctr, fetch_pc, instr_valid, halted, ras_err,
                 m_pc, m_fpc, m_valid, m_halted, m_err);
      end
    end
    reset_n = 1; halt = 0; ret = 0; call = 0; br_taken = 0; stall = 0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_wrap();
    test_call_ret();
    test_nested_calls();
    test_stall_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, want completion before 500000");
    $fatal(1);
  end

endmodule
